// File: rtl/ic_pkg.sv
// Shared constants and address type for the CPU architectural register file.
package ic_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned REG_AW = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/param_reg_file_wen_reg.sv
// Single-bit dff cell and a WIDTH-bit write-enabled register built from it.
// Reset is synchronous, active-high, and wins over the write enable.
module dff (
  input  logic clk,
  input  logic rst,
  input  logic wen,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

module wen_reg
  import ic_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    dff u_dff (
      .q   (q[b]),
      .d   (d[b]),
      .wen (wen),
      .clk (clk),
      .rst (rst)
    );
  end

endmodule

// File: rtl/param_reg_file.sv
// DEPTH x WIDTH register file: two combinational read ports, one clocked write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module param_reg_file
  import ic_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_W,
  parameter int unsigned DEPTH    = NREGS,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] words [DEPTH];

  // One bank per word; word 0 is hard-wired to zero when it is the zero register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG && i == 0) begin : g_zero
      assign words[i] = '0;
    end else begin : g_bank
      logic wen;
      assign wen = wr_en && (wr_addr == AW'(i));
      wen_reg #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .rst (rst),
        .wen (wen),
        .d   (wr_data),
        .q   (words[i])
      );
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = wr_en && !rst && !(ZERO_REG && wr_addr == '0);
`endif

  // Read muxes, with the optional forwarding stage on their outputs.
  always_comb begin
    rd_data_a = words[rd_addr_a];
    rd_data_b = words[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && wr_addr == rd_addr_a) rd_data_a = wr_data;
    if (fwd_ok && wr_addr == rd_addr_b) rd_data_b = wr_data;
`endif
  end

endmodule
